bank_port_arbiter: RTL and testbench
====================================

BANK_PORT_ARBITER -- requirements
Module: bank_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_RAMS, default 2, meaning the number of banks behind port A.
REQ-002 SHALL have parameter A_WID, default 10, meaning the per-bank word address width.
REQ-003 SHALL have parameter D_WID, default 32, meaning the data width.
REQ-004 SHALL derive local BS_WID = $clog2(NUM_RAMS) (minimum 1), meaning the bank-select width.
REQ-005 SHALL have clk, input, 1, the single clock; all state is rising-edge.
REQ-006 SHALL have rst_n, input, 1, the reset: asynchronous, active-low.
REQ-007 SHALL have req_valid, input, [1:0], the request valid per requester (0 = host bus, 1 = GEMM engine).
REQ-008 SHALL have req_ready, output, [1:0], the per-requester grant/accept.
REQ-009 SHALL have req_we, input, [1:0], the write enable per requester.
REQ-010 SHALL have req_addr, input, [BS_WID+A_WID-1:0] x2: low BS_WID bits select the bank, upper A_WID bits are the word address.
REQ-011 SHALL have req_wdata, input, [D_WID-1:0] x2, the write data.
REQ-012 SHALL have rsp_valid, output, [1:0], read data valid per requester.
REQ-013 SHALL have rsp_rdata, output, [D_WID-1:0] x2, the read data.
REQ-014 SHALL have ena, output, [NUM_RAMS-1:0], the bank port-A enable.
REQ-015 SHALL have wea, output, [NUM_RAMS-1:0], the bank port-A write enable.
REQ-016 SHALL have addra, output, [A_WID-1:0] x NUM_RAMS, the bank port-A address.
REQ-017 SHALL have dina, output, [D_WID-1:0] x NUM_RAMS, the bank port-A write data.
REQ-018 SHALL have douta, input, [D_WID-1:0] x NUM_RAMS, the bank port-A read data (1-cycle registered read).
REQ-019 SHALL have conflict_cnt, output, 16, a saturating count of same-cycle same-bank collisions.

Function
REQ-020 SHALL grant, each cycle and independently per bank, at most one requester whose req_valid=1 targets that bank.
REQ-021 SHALL, when only one requester targets a bank, grant it with no arbitration penalty.
REQ-022 SHALL, when both requesters target the same bank, grant the requester indicated by that bank's round-robin pointer rr[b], then set rr[b] to the other requester.
REQ-023 SHALL leave rr[b] unchanged on non-conflicting grants.
REQ-024 SHALL make req_ready[r] combinational: 1 iff requester r is granted this cycle; a transfer occurs on req_valid & req_ready.
REQ-025 SHALL require the requester to hold req_we, req_addr and req_wdata stable while valid and not ready; the arbiter does not buffer requests.
REQ-026 SHALL, for each granted bank b, drive ena[b]=1, wea[b]=req_we of the winner, addra[b]=word address and dina[b]=wdata of the winner; ungranted banks SHALL see ena=wea=0.
REQ-027 SHALL, on a granted read, assert rsp_valid[r] exactly one cycle later with rsp_rdata[r]=douta[registered bank index].
REQ-028 SHALL keep rsp_valid low after writes; rsp_rdata holds its last value when rsp_valid=0.
REQ-029 SHALL sustain one transfer per requester per cycle when the two requesters target different banks (back-to-back reads pipelined, no bubbles).
REQ-030 SHALL never backpressure responses; requesters always accept rsp.
REQ-031 SHALL increment conflict_cnt on each cycle in which at least one bank sees both requesters, saturating at 16'hFFFF.
REQ-032 SHALL treat a bank-select value >= NUM_RAMS (non-power-of-2 NUM_RAMS) as a no-grant: req_ready=0 indefinitely.

Reset
REQ-033 SHALL, while rst_n=0, clear rr[] to 0 (host priority), rsp_valid to 0, rsp_rdata to 0, the registered bank indices to 0 and conflict_cnt to 0.
REQ-034 SHALL, while rst_n=0, force req_ready, ena and wea to 0 regardless of req_valid.
REQ-035 SHALL drop a read granted in the cycle before reset assertion: no rsp_valid after release.

Structure
REQ-036 SHALL place the requester-index constants (REQ_HOST=0, REQ_GEMM=1) and the default A_WID/D_WID/NUM_RAMS in the shared GEMM package.
REQ-037 SHALL use one sub-module, bank_rr_arb: a 2-input round-robin arbiter with a pointer flop, instantiated once per bank in a generate loop.

Verification
REQ-038 SHALL cover: host writes 0xDEAD_BEEF to bank 0, addr 5, then reads it -> ena[0]=1 and wea[0]=1 in the grant cycle; rsp_valid[0]=1 one cycle after the read with rdata 0xDEAD_BEEF.
REQ-039 SHALL cover: host reads bank 0 while GEMM reads bank 1 in the same cycle -> both req_ready=1; both rsp next cycle; conflict_cnt unchanged.
REQ-040 SHALL cover: both requesters hold reads to bank 1 for 4 cycles -> grants alternate host, GEMM, host, GEMM; conflict_cnt=4.
REQ-041 SHALL cover: GEMM streams 8 back-to-back reads to banks 0,1,0,1 with no host traffic -> 8 consecutive rsp_valid cycles with data in order.
REQ-042 SHALL cover: rst_n pulsed low the cycle after a granted read -> rsp_valid stays 0; rr reset so the next conflict grants the host.
REQ-043 SHALL cover: conflict_cnt preloaded near saturation by 65 540 forced conflicts -> holds at 0xFFFF.

Source files
------------

// File: rtl/bank_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bank_port_arbiter_pkg
// Description : Shared GEMM package - requester indices, default bank
//               geometry and the bank-select width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package bank_port_arbiter_pkg;

    // Requester indices on the two-requester side of the arbiter
    localparam int REQ_HOST = 0;
    localparam int REQ_GEMM = 1;

    // Default bank geometry
    localparam int DEF_NUM_RAMS = 2;
    localparam int DEF_A_WID    = 10;
    localparam int DEF_D_WID    = 32;

    // Collision counter width
    localparam int CNT_WID = 16;

    // Round-robin pointer: which requester wins the next collision
    typedef enum logic {
        RR_HOST = 1'b0,
        RR_GEMM = 1'b1
    } rr_ptr_e;

    // Bank-select width; a single bank still carries one select bit
    function automatic int bs_width(input int num_rams);
        return (num_rams > 1) ? $clog2(num_rams) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bank_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : bank_rr_arb
// Description : Two-input round-robin arbiter for one bank. A lone request
//               is granted immediately; a collision is resolved by the
//               pointer, which then moves to the losing requester.
// Revision    : 1.0 - initial release
// ============================================================================
module bank_rr_arb
    import bank_port_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o,
    output logic       conflict_o
);

    rr_ptr_e rr_q;
    rr_ptr_e rr_d;

    // Grant selection and pointer update; pointer only moves on a collision
    always_comb begin
        gnt_o      = 2'b00;
        conflict_o = 1'b0;
        rr_d       = rr_q;
        case (req_i)
            2'b01: gnt_o = 2'b01;
            2'b10: gnt_o = 2'b10;
            2'b11: begin
                conflict_o = 1'b1;
                if (rr_q == RR_HOST) begin
                    gnt_o = 2'b01;
                    rr_d  = RR_GEMM;
                end else begin
                    gnt_o = 2'b10;
                    rr_d  = RR_HOST;
                end
            end
            default: gnt_o = 2'b00;
        endcase
    end

    // Pointer register; reset gives the host first priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= RR_HOST;
        end else begin
            rr_q <= rr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bank_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bank_port_arbiter
// Description : Shares NUM_RAMS single-port bank ports (port A) between the
//               host bus and the GEMM engine. Per-bank round-robin on
//               collisions, combinational ready, 1-cycle read response.
// Revision    : 1.0 - initial release
// ============================================================================
module bank_port_arbiter
    import bank_port_arbiter_pkg::*;
#(
    parameter  int NUM_RAMS = DEF_NUM_RAMS,
    parameter  int A_WID    = DEF_A_WID,
    parameter  int D_WID    = DEF_D_WID,
    localparam int BS_WID   = bs_width(NUM_RAMS),
    localparam int AD_WID   = BS_WID + A_WID
)
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [1:0]                req_valid_i,
    output logic [1:0]                req_ready_o,
    input  logic [1:0]                req_we_i,
    input  logic [2*AD_WID-1:0]       req_addr_i,
    input  logic [2*D_WID-1:0]        req_wdata_i,
    output logic [1:0]                rsp_valid_o,
    output logic [2*D_WID-1:0]        rsp_rdata_o,
    output logic [NUM_RAMS-1:0]       ena_o,
    output logic [NUM_RAMS-1:0]       wea_o,
    output logic [NUM_RAMS*A_WID-1:0] addra_o,
    output logic [NUM_RAMS*D_WID-1:0] dina_o,
    input  logic [NUM_RAMS*D_WID-1:0] douta_i,
    output logic [CNT_WID-1:0]        conflict_cnt_o
);

    localparam logic [CNT_WID-1:0] C_CNT_MAX = {CNT_WID{1'b1}};

    // Per-requester address split and per-bank arbitration wiring
    logic [BS_WID-1:0] w_bank_sel [2];
    logic [A_WID-1:0]  w_word     [2];
    logic [D_WID-1:0]  w_wdata    [2];
    logic [1:0]        w_bank_req [NUM_RAMS];
    logic [1:0]        w_gnt      [NUM_RAMS];
    logic [NUM_RAMS-1:0] w_conf;
    logic [D_WID-1:0]  w_dout     [NUM_RAMS];

    // Response pipeline and collision counter state
    logic [1:0]        rd_pend_q, rd_pend_d;
    logic [BS_WID-1:0] rd_bank_q [2];
    logic [BS_WID-1:0] rd_bank_d [2];
    logic [D_WID-1:0]  hold_q    [2];
    logic [D_WID-1:0]  hold_d    [2];
    logic [CNT_WID-1:0] cnt_q, cnt_d;

    genvar r, b;

    generate
        for (r = 0; r < 2; r++) begin : g_req_split
            assign w_bank_sel[r] = req_addr_i[r*AD_WID +: BS_WID];
            assign w_word[r]     = req_addr_i[r*AD_WID+BS_WID +: A_WID];
            assign w_wdata[r]    = req_wdata_i[r*D_WID +: D_WID];
        end

        for (b = 0; b < NUM_RAMS; b++) begin : g_bank
            logic w_win;

            // Reset masks requests so nothing is granted while rst_n is low;
            // an out-of-range select never matches any bank.
            assign w_bank_req[b][0] = rst_n & req_valid_i[0]
                                      & (w_bank_sel[0] == BS_WID'(b));
            assign w_bank_req[b][1] = rst_n & req_valid_i[1]
                                      & (w_bank_sel[1] == BS_WID'(b));

            bank_rr_arb u_arb (
                .clk        (clk),
                .rst_n      (rst_n),
                .req_i      (w_bank_req[b]),
                .gnt_o      (w_gnt[b]),
                .conflict_o (w_conf[b])
            );

            assign w_win                     = w_gnt[b][REQ_GEMM];
            assign ena_o[b]                  = |w_gnt[b];
            assign wea_o[b]                  = (|w_gnt[b]) & req_we_i[w_win];
            assign addra_o[b*A_WID +: A_WID] = w_word[w_win];
            assign dina_o[b*D_WID +: D_WID]  = w_wdata[w_win];
            assign w_dout[b]                 = douta_i[b*D_WID +: D_WID];
        end

        for (r = 0; r < 2; r++) begin : g_rsp_out
            // Fresh bank data on the response cycle, otherwise the held word
            assign rsp_rdata_o[r*D_WID +: D_WID] =
                rd_pend_q[r] ? w_dout[rd_bank_q[r]] : hold_q[r];
        end
    endgenerate

    assign rsp_valid_o    = rd_pend_q;
    assign conflict_cnt_o = cnt_q;

    // A requester is ready when any bank granted it this cycle
    always_comb begin
        req_ready_o = 2'b00;
        for (int i = 0; i < NUM_RAMS; i++) begin
            req_ready_o = req_ready_o | w_gnt[i];
        end
    end

    // Next state of the response pipeline and the saturating counter
    always_comb begin
        rd_pend_d = req_valid_i & req_ready_o & ~req_we_i;
        for (int i = 0; i < 2; i++) begin
            rd_bank_d[i] = rd_bank_q[i];
            hold_d[i]    = hold_q[i];
            if (req_valid_i[i] && req_ready_o[i] && !req_we_i[i]) begin
                rd_bank_d[i] = w_bank_sel[i];
            end
            if (rd_pend_q[i]) begin
                hold_d[i] = w_dout[rd_bank_q[i]];
            end
        end
        cnt_d = cnt_q;
        if ((|w_conf) && (cnt_q != C_CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers; reset also discards a read granted just before it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend_q    <= 2'b00;
            rd_bank_q[0] <= '0;
            rd_bank_q[1] <= '0;
            hold_q[0]    <= '0;
            hold_q[1]    <= '0;
            cnt_q        <= '0;
        end else begin
            rd_pend_q    <= rd_pend_d;
            rd_bank_q[0] <= rd_bank_d[0];
            rd_bank_q[1] <= rd_bank_d[1];
            hold_q[0]    <= hold_d[0];
            hold_q[1]    <= hold_d[1];
            cnt_q        <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bank_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bank_port_arbiter
// Description : Self-checking bench for bank_port_arbiter with a bank RAM
//               model and a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bank_port_arbiter;

    localparam int NR  = 2;
    localparam int AW  = 10;
    localparam int DW  = 32;
    localparam int BW  = 1;
    localparam int ADW = BW + AW;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        req_valid, req_ready, req_we, rsp_valid;
    logic [2*ADW-1:0]  req_addr;
    logic [2*DW-1:0]   req_wdata, rsp_rdata;
    logic [NR-1:0]     ena, wea;
    logic [NR*AW-1:0]  addra;
    logic [NR*DW-1:0]  dina, douta;
    logic [15:0]       conflict_cnt;

    bank_port_arbiter #(.NUM_RAMS(NR), .A_WID(AW), .D_WID(DW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_we_i       (req_we),
        .req_addr_i     (req_addr),
        .req_wdata_i    (req_wdata),
        .rsp_valid_o    (rsp_valid),
        .rsp_rdata_o    (rsp_rdata),
        .ena_o          (ena),
        .wea_o          (wea),
        .addra_o        (addra),
        .dina_o         (dina),
        .douta_i        (douta),
        .conflict_cnt_o (conflict_cnt)
    );

    always #5 clk = ~clk;

    // Stimulus variables (one slot per requester)
    bit          v   [2];
    bit          we  [2];
    int          bk  [2];
    int          wa  [2];
    logic [31:0] wd  [2];

    assign req_valid = {v[1], v[0]};
    assign req_we    = {we[1], we[0]};
    assign req_addr  = {AW'(wa[1]), BW'(bk[1]), AW'(wa[0]), BW'(bk[0])};
    assign req_wdata = {wd[1], wd[0]};

    // Bank RAMs: 1-cycle registered read, read-before-write
    logic [DW-1:0] ram [NR][1024];
    logic [DW-1:0] dq  [NR];
    for (genvar gb = 0; gb < NR; gb++) begin : g_ram
        assign douta[gb*DW +: DW] = dq[gb];
        always @(posedge clk) begin
            if (ena[gb]) begin
                dq[gb] <= ram[gb][addra[gb*AW +: AW]];
                if (wea[gb]) ram[gb][addra[gb*AW +: AW]] <= dina[gb*DW +: DW];
            end
        end
    end

    // Reference model state
    bit          m_rr    [NR];
    bit          m_pend  [2];
    logic [31:0] m_pdata [2];
    logic [31:0] m_hold  [2];
    int          m_cnt;
    bit          m_g     [2];
    logic [31:0] emem    [NR][1024];

    // Observations captured in the last step
    logic [1:0]  obs_ready, obs_rsp_valid;
    logic [31:0] obs_rdata0, obs_rdata1;
    logic [15:0] obs_cnt;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < NR; b++) m_rr[b] = 1'b0;
        for (int r = 0; r < 2; r++) begin
            m_pend[r]  = 1'b0;
            m_hold[r]  = '0;
            m_pdata[r] = '0;
            m_g[r]     = 1'b0;
        end
        m_cnt = 0;
    endtask

    // One clock: predict, check at negedge, advance model at posedge
    task automatic step();
        bit g [2];
        bit busy [NR];
        int win [NR];
        bit conf_b [NR];
        bit conf;
        bit h, m;
        g[0] = 0; g[1] = 0; conf = 0;
        for (int b = 0; b < NR; b++) begin
            busy[b] = 0; win[b] = 0; conf_b[b] = 0;
            h = rst_n && v[0] && (bk[0] == b);
            m = rst_n && v[1] && (bk[1] == b);
            if (h && m) begin
                conf = 1; conf_b[b] = 1; win[b] = int'(m_rr[b]);
            end else if (m) begin
                win[b] = 1;
            end
            if (h || m) begin
                busy[b] = 1; g[win[b]] = 1;
            end
        end
        @(negedge clk);
        obs_ready     = req_ready;
        obs_rsp_valid = rsp_valid;
        obs_rdata0    = rsp_rdata[31:0];
        obs_rdata1    = rsp_rdata[63:32];
        obs_cnt       = conflict_cnt;
        check_eq("ready", 64'(req_ready), 64'({g[1], g[0]}));
        for (int b = 0; b < NR; b++) begin
            check_eq("ena", 64'(ena[b]), 64'(busy[b]));
            check_eq("wea", 64'(wea[b]), 64'(busy[b] && we[win[b]]));
            if (busy[b]) begin
                check_eq("addra", 64'(addra[b*AW +: AW]), 64'(wa[win[b]]));
                if (we[win[b]]) check_eq("dina", 64'(dina[b*DW +: DW]), 64'(wd[win[b]]));
            end
        end
        for (int r = 0; r < 2; r++) begin
            check_eq("rsp_valid", 64'(rsp_valid[r]), 64'(m_pend[r]));
            check_eq("rsp_rdata", 64'(rsp_rdata[r*DW +: DW]),
                     64'(m_pend[r] ? m_pdata[r] : m_hold[r]));
        end
        check_eq("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
        @(posedge clk);
        for (int r = 0; r < 2; r++) begin
            if (m_pend[r]) m_hold[r] = m_pdata[r];
            m_pend[r] = g[r] && !we[r];
            if (m_pend[r]) m_pdata[r] = emem[bk[r]][wa[r]];
        end
        for (int r = 0; r < 2; r++) begin
            if (g[r] && we[r]) emem[bk[r]][wa[r]] = wd[r];
        end
        for (int b = 0; b < NR; b++) if (conf_b[b]) m_rr[b] = !m_rr[b];
        if (conf && m_cnt < 65535) m_cnt++;
        m_g = g;
        #1;
    endtask

    task automatic set_req(input int r, input bit vv, input bit ww, input int bb,
                           input int aa, input logic [31:0] dd);
        v[r] = vv; we[r] = ww; bk[r] = bb; wa[r] = aa; wd[r] = dd;
    endtask

    task automatic do_reset();
        set_req(0, 0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        model_reset();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        for (int b = 0; b < NR; b++) begin
            for (int a = 0; a < 1024; a++) begin
                ram[b][a]  = '0;
                emem[b][a] = '0;
            end
            dq[b] = '0;
        end
        set_req(0, 0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0, 0);
        model_reset();
        #1;
        do_reset();
        check_eq("reset_cnt", 64'(obs_cnt), 64'h0);
        check_eq("reset_rsp_valid", 64'(obs_rsp_valid), 64'h0);
        check_eq("reset_ready", 64'(obs_ready), 64'h0);

        // Host write then read of bank 0, word 5
        set_req(0, 1, 1, 0, 5, 32'hDEAD_BEEF);
        step();
        check_eq("wr_ready", 64'(obs_ready), 64'h1);
        set_req(0, 1, 0, 0, 5, 32'h0);
        step();
        set_req(0, 0, 0, 0, 0, 32'h0);
        step();
        check_eq("rd_rsp_valid", 64'(obs_rsp_valid), 64'h1);
        check_eq("rd_rdata", 64'(obs_rdata0), 64'hDEAD_BEEF);

        // Parallel reads to different banks
        set_req(0, 1, 0, 0, 5, 0);
        set_req(1, 1, 0, 1, 7, 0);
        step();
        check_eq("par_ready", 64'(obs_ready), 64'h3);
        set_req(0, 0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0, 0);
        step();
        check_eq("par_rsp", 64'(obs_rsp_valid), 64'h3);
        check_eq("par_rdata0", 64'(obs_rdata0), 64'hDEAD_BEEF);
        check_eq("par_cnt", 64'(obs_cnt), 64'h0);

        // Four-cycle collision on bank 1: host, GEMM, host, GEMM
        do_reset();
        set_req(0, 1, 0, 1, 3, 0);
        set_req(1, 1, 0, 1, 4, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("rr_alt", 64'(obs_ready), (i % 2 == 0) ? 64'h1 : 64'h2);
        end
        set_req(0, 0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0, 0);
        step();
        check_eq("rr_cnt4", 64'(obs_cnt), 64'h4);

        // GEMM streams 8 reads alternating banks after host fills them
        for (int i = 0; i < 8; i++) begin
            set_req(0, 1, 1, i % 2, 16 + i, 32'h1000_0000 + 32'(i * 32'h111));
            step();
        end
        set_req(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            set_req(1, 1, 0, i % 2, 16 + i, 0);
            step();
            if (i > 0) check_eq("stream_rdata", 64'(obs_rdata1),
                                64'h1000_0000 + 64'((i - 1) * 32'h111));
        end
        set_req(1, 0, 0, 0, 0, 0);
        step();
        check_eq("stream_last", 64'(obs_rdata1), 64'h1000_0000 + 64'(7 * 32'h111));
        check_eq("stream_last_v", 64'(obs_rsp_valid), 64'h2);

        // Reset right after a granted read drops the response
        set_req(0, 1, 1, 1, 9, 32'h5555_AAAA);
        set_req(1, 1, 0, 1, 9, 0);
        step();
        set_req(0, 1, 0, 0, 5, 0);
        set_req(1, 0, 0, 0, 0, 0);
        step();
        set_req(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        model_reset();
        step();
        check_eq("rst_drop_v", 64'(obs_rsp_valid), 64'h0);
        check_eq("rst_rdata", 64'(obs_rdata0), 64'h0);
        rst_n = 1'b1;
        step();
        check_eq("rst_after_v", 64'(obs_rsp_valid), 64'h0);
        set_req(0, 1, 0, 1, 2, 0);
        set_req(1, 1, 0, 1, 2, 0);
        step();
        check_eq("rst_rr_host", 64'(obs_ready), 64'h1);

        // Randomized traffic honouring the hold-until-ready rule
        for (int c = 0; c < 3000; c++) begin
            for (int r = 0; r < 2; r++) begin
                if (!v[r] || m_g[r]) begin
                    set_req(r, ($urandom % 4) != 0, $urandom % 2, $urandom % NR,
                            $urandom % 16, $urandom);
                end
            end
            step();
        end

        // Saturation of the collision counter
        do_reset();
        set_req(0, 1, 0, 0, 1, 0);
        set_req(1, 1, 0, 0, 2, 0);
        for (int c = 0; c < 65540; c++) step();
        set_req(0, 0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0, 0);
        step();
        check_eq("sat_cnt", 64'(obs_cnt), 64'hFFFF);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
